step_pulse_shaper: RTL and testbench

//  Sits between the DDA move executor and the step/dir consumers (microstepper or

---
 rtl/step_pulse_shaper.sv | 159 +++++++++++++++
 tb/tb_step_pulse_shaper.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/step_pulse_shaper.sv
// Step/dir pulse shaper: queues one-cycle DDA step strobes and replays them as
// step/dir pulses with fixed dir-setup, step-high and step-low timing.
module step_pulse_shaper #(
   parameter int DIR_SETUP_CYCLES = 8,
   parameter int STEP_HIGH_CYCLES = 16,
   parameter int STEP_LOW_CYCLES  = 16,
   parameter int FIFO_BITS        = 3,
   parameter int POS_BITS         = 64
) (
   input  logic                CLK,
   input  logic                resetn,
   input  logic                enable,
   input  logic                step_req,
   input  logic                dir_req,
   input  logic                position_load,
   input  logic [POS_BITS-1:0] position_load_value,
   input  logic                overrun_clr,
   output logic                step_out,
   output logic                dir_out,
   output logic [POS_BITS-1:0] position,
   output logic [FIFO_BITS:0]  pending,
   output logic                busy,
   output logic                overrun
);

   localparam int DEPTH   = 2 ** FIFO_BITS;
   localparam int MAX_DH  = (DIR_SETUP_CYCLES > STEP_HIGH_CYCLES) ? DIR_SETUP_CYCLES : STEP_HIGH_CYCLES;
   localparam int CNT_MAX = (MAX_DH > STEP_LOW_CYCLES) ? MAX_DH : STEP_LOW_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0]   SETUP_LOAD = CNT_W'(DIR_SETUP_CYCLES - 1);
   localparam logic [CNT_W-1:0]   HIGH_LOAD  = CNT_W'(STEP_HIGH_CYCLES - 1);
   localparam logic [CNT_W-1:0]   LOW_LOAD   = CNT_W'(STEP_LOW_CYCLES - 1);
   localparam logic [FIFO_BITS:0] DEPTH_V    = (FIFO_BITS + 1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, DIR_SETUP, STEP_HIGH, STEP_LOW} state_t;

   state_t               state, state_nxt;
   logic [CNT_W-1:0]     cnt, cnt_nxt;
   logic                 step_nxt, dir_nxt, step_entry, pop;
   logic [POS_BITS-1:0]  pos_base, pos_delta, pos_nxt;

   // Requests are staged one cycle before entering the queue.
   logic                 req_q, dir_q;
   logic                 mem [DEPTH];
   logic [FIFO_BITS-1:0] rd_ptr, wr_ptr;
   logic [FIFO_BITS:0]   count_nxt;
   logic                 push, full, accept, drop, head;

   assign head   = mem[rd_ptr];
   assign push   = req_q & enable;
   assign full   = (pending == DEPTH_V);
   assign accept = push & (~full | pop);
   assign drop   = push & full & ~pop;

   // NOTE: every signal gets a default before the case, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      step_nxt   = step_out;
      dir_nxt    = dir_out;
      step_entry = 1'b0;
      pop        = 1'b0;
      case (state)
         IDLE: begin
            if (enable && (pending != '0)) begin
               pop = 1'b1;
               if (head != dir_out) begin
                  dir_nxt   = head;
                  cnt_nxt   = SETUP_LOAD;
                  state_nxt = DIR_SETUP;
               end else begin
                  step_entry = 1'b1;
               end
            end
         end
         DIR_SETUP: begin
            if (cnt == '0) step_entry = 1'b1;
            else           cnt_nxt    = cnt - CNT_W'(1);
         end
         STEP_HIGH: begin
            if (cnt == '0) begin
               step_nxt  = 1'b0;
               cnt_nxt   = LOW_LOAD;
               state_nxt = STEP_LOW;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         STEP_LOW: begin
            if (cnt == '0) state_nxt = IDLE;
            else           cnt_nxt   = cnt - CNT_W'(1);
         end
         default: state_nxt = IDLE;
      endcase
      if (step_entry) begin
         step_nxt  = 1'b1;
         cnt_nxt   = HIGH_LOAD;
         state_nxt = STEP_HIGH;
      end
   end

   // dir_out already holds the pulse direction at STEP_HIGH entry in both paths.
   always_comb begin
      pos_delta = dir_out ? POS_BITS'(1) : {POS_BITS{1'b1}};
      pos_base  = position_load ? position_load_value : position;
      pos_nxt   = step_entry ? (pos_base + pos_delta) : pos_base;
   end

   always_comb begin
      count_nxt = pending;
      if (!enable)              count_nxt = '0;
      else if (accept && !pop)  count_nxt = pending + (FIFO_BITS + 1)'(1);
      else if (!accept && pop)  count_nxt = pending - (FIFO_BITS + 1)'(1);
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge CLK) begin
      if (!resetn) begin
         state    <= IDLE;
         cnt      <= '0;
         step_out <= 1'b0;
         dir_out  <= 1'b0;
         position <= '0;
         pending  <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         req_q    <= 1'b0;
         dir_q    <= 1'b0;
         busy     <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         step_out <= step_nxt;
         dir_out  <= dir_nxt;
         position <= pos_nxt;
         pending  <= count_nxt;
         req_q    <= step_req & enable;
         dir_q    <= dir_req;
         busy     <= (state_nxt != IDLE) || (count_nxt != '0);
         if (!enable) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
         end else begin
            if (pop)    rd_ptr <= rd_ptr + FIFO_BITS'(1);
            if (accept) wr_ptr <= wr_ptr + FIFO_BITS'(1);
         end
         if (drop)             overrun <= 1'b1;
         else if (overrun_clr) overrun <= 1'b0;
      end
   end

   // NOTE: queue storage is not reset; an entry is only read after it has been written.
   always_ff @(posedge CLK) begin
      if (accept) mem[wr_ptr] <= dir_q;
   end

endmodule

// File: tb/tb_step_pulse_shaper.sv
// Self-checking bench for step_pulse_shaper: timeline model compared every cycle,
// plus directed scenarios with hand-computed pulse timing and position values.
module tb_step_pulse_shaper;

   localparam int D = 8, H = 16, L = 16, FB = 3, PB = 64, DEPTH = 8;

   logic          CLK = 1'b0;
   logic          resetn = 1'b0, enable = 1'b0, step_req = 1'b0, dir_req = 1'b0;
   logic          position_load = 1'b0, overrun_clr = 1'b0;
   logic [PB-1:0] position_load_value = '0;
   logic          step_out, dir_out, busy, overrun;
   logic [PB-1:0] position;
   logic [FB:0]   pending;

   always #5 CLK = ~CLK;

   step_pulse_shaper #(.DIR_SETUP_CYCLES(D), .STEP_HIGH_CYCLES(H), .STEP_LOW_CYCLES(L),
                       .FIFO_BITS(FB), .POS_BITS(PB)) dut (
      .CLK(CLK), .resetn(resetn), .enable(enable), .step_req(step_req), .dir_req(dir_req),
      .position_load(position_load), .position_load_value(position_load_value),
      .overrun_clr(overrun_clr), .step_out(step_out), .dir_out(dir_out),
      .position(position), .pending(pending), .busy(busy), .overrun(overrun));

   int n_cmp = 0, n_bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, cyc);
      end
   endtask

   // Timeline model: each popped request schedules a rise, a fall and the next
   // earliest pop, rather than stepping through controller states.
   longint        cyc = 0;
   bit            m_valid = 1'b0;
   bit            q[$];
   bit            stage_req, stage_dir, m_dir, m_over, m_h, m_drop;
   logic [PB-1:0] m_pos, m_base;
   longint        rise_at = -1, fall_at = -1, free_at = 0;

   always @(posedge CLK) begin
      cyc++;
      if (!resetn) begin
         q.delete();
         stage_req = 0; stage_dir = 0; m_dir = 0; m_over = 0; m_pos = '0;
         rise_at = -1; fall_at = -1; free_at = 0; m_valid = 1;
      end else begin
         m_drop = 0;
         if (enable && cyc >= free_at && q.size() > 0) begin
            m_h = q.pop_front();
            if (m_h != m_dir) begin
               m_dir   = m_h;
               rise_at = cyc + D;
            end else begin
               rise_at = cyc;
            end
            fall_at = rise_at + H;
            free_at = fall_at + L + 1;
         end
         if (!enable) begin
            q.delete();
            stage_req = 0;
         end else begin
            if (stage_req) begin
               if (q.size() < DEPTH) q.push_back(stage_dir);
               else                  m_drop = 1;
            end
            stage_req = step_req;
            stage_dir = dir_req;
         end
         if (m_drop)           m_over = 1;
         else if (overrun_clr) m_over = 0;
         m_base = position_load ? position_load_value : m_pos;
         if (cyc == rise_at) m_pos = m_dir ? m_base + 64'd1 : m_base - 64'd1;
         else                m_pos = m_base;
      end
   end

   always @(negedge CLK) begin
      if (m_valid) begin
         check("step_out", 64'(step_out), 64'(cyc >= rise_at && cyc < fall_at));
         check("dir_out",  64'(dir_out),  64'(m_dir));
         check("position", position,      m_pos);
         check("pending",  64'(pending),  64'(q.size()));
         check("busy",     64'(busy),     64'((cyc < free_at - 1) || (q.size() != 0)));
         check("overrun",  64'(overrun),  64'(m_over));
      end
   end

   // Pulse-shape monitor feeding the directed checks.
   longint last_rise, last_fall, last_dir_chg = -1000, last_busy_fall;
   longint width_last, setup_last, min_sp, max_sp, setup_min, setup_max;
   int     n_rise, dir_bad, peak;
   logic   p_step = 0, p_dir = 0, p_busy = 0;

   always @(negedge CLK) begin
      if (m_valid) begin
         if (step_out && !p_step) begin
            n_rise++;
            if (last_rise >= 0) begin
               if (cyc - last_rise < min_sp) min_sp = cyc - last_rise;
               if (cyc - last_rise > max_sp) max_sp = cyc - last_rise;
            end
            last_rise  = cyc;
            setup_last = cyc - last_dir_chg;
            if (setup_last < setup_min) setup_min = setup_last;
            if (setup_last > setup_max) setup_max = setup_last;
         end
         if (!step_out && p_step) begin
            last_fall  = cyc;
            width_last = cyc - last_rise;
         end
         if (dir_out != p_dir) begin
            last_dir_chg = cyc;
            if (p_step || (last_fall >= 0 && cyc - last_fall <= L)) dir_bad++;
         end
         if (!busy && p_busy) last_busy_fall = cyc;
         if (int'(pending) > peak) peak = int'(pending);
         p_step = step_out; p_dir = dir_out; p_busy = busy;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge CLK);
         #1;
      end
   endtask

   task automatic clear_stats();
      n_rise = 0; dir_bad = 0; peak = 0;
      last_rise = -1; last_fall = -1; last_busy_fall = -1;
      min_sp = 1000000; max_sp = 0; setup_min = 1000000; setup_max = 0;
   endtask

   task automatic wait_idle(input string name, input int budget);
      int k = 0;
      tick(3);
      while ((busy || step_out) && k < budget) begin
         tick(1);
         k++;
      end
      check(name, 64'(k < budget), 64'd1);
   endtask

   task automatic wait_step(input string name, input int budget);
      int k = 0;
      while (!step_out && k < budget) begin
         tick(1);
         k++;
      end
      check(name, 64'(k < budget), 64'd1);
   endtask

   task automatic one_req(input logic d);
      dir_req  = d;
      step_req = 1'b1;
      tick(1);
      step_req = 1'b0;
   endtask

   task automatic pulse_reset();
      resetn = 1'b0;
      tick(1);
      resetn = 1'b1;
   endtask

   longint e0;

   initial begin
      clear_stats();
      tick(3);
      check("rst_step", 64'(step_out), 64'd0);
      check("rst_dir",  64'(dir_out),  64'd0);
      check("rst_pos",  position,      64'd0);
      check("rst_pend", 64'(pending),  64'd0);
      check("rst_busy", 64'(busy),     64'd0);
      check("rst_ovr",  64'(overrun),  64'd0);
      resetn = 1'b1;
      enable = 1'b1;
      tick(2);

      // Single minus step, no direction change.
      clear_stats();
      e0 = cyc + 1;
      one_req(1'b0);
      wait_idle("t1_idle", 200);
      check("t1_latency", 64'(last_rise - e0), 64'd2);
      check("t1_width",   64'(width_last), 64'd16);
      check("t1_pulses",  64'(n_rise), 64'd1);
      check("t1_pos",     position, 64'hFFFF_FFFF_FFFF_FFFF);
      check("t1_dir",     64'(dir_out), 64'd0);
      check("t1_busy",    64'(last_busy_fall - last_rise), 64'd32);

      // Plus step with direction change from reset.
      pulse_reset();
      clear_stats();
      e0 = cyc + 1;
      one_req(1'b1);
      wait_idle("t2_idle", 200);
      check("t2_dir",     64'(dir_out), 64'd1);
      check("t2_setup",   64'(setup_last), 64'd8);
      check("t2_latency", 64'(last_rise - e0), 64'd10);
      check("t2_pos",     position, 64'd1);

      // Burst of 10 into an 8-deep queue.
      pulse_reset();
      clear_stats();
      dir_req  = 1'b0;
      step_req = 1'b1;
      tick(10);
      step_req = 1'b0;
      wait_idle("t3_idle", 1000);
      check("t3_peak",   64'(peak), 64'd8);
      check("t3_ovr",    64'(overrun), 64'd1);
      check("t3_pulses", 64'(n_rise), 64'd9);
      check("t3_min_sp", 64'(min_sp), 64'd33);
      check("t3_max_sp", 64'(max_sp), 64'd33);
      check("t3_pos",    position, 64'hFFFF_FFFF_FFFF_FFF7);

      // Alternating directions from position 0.
      position_load_value = '0;
      position_load = 1'b1;
      tick(1);
      position_load = 1'b0;
      clear_stats();
      for (int i = 0; i < 4; i++) begin
         dir_req  = (i % 2 == 0);
         step_req = 1'b1;
         tick(1);
      end
      step_req = 1'b0;
      wait_idle("t4_idle", 1000);
      check("t4_pulses",  64'(n_rise), 64'd4);
      check("t4_setupmn", 64'(setup_min), 64'd8);
      check("t4_setupmx", 64'(setup_max), 64'd8);
      check("t4_dirbad",  64'(dir_bad), 64'd0);
      check("t4_pos",     position, 64'd0);
      check("t4_ovr",     64'(overrun), 64'd1);

      // Disable mid pulse with three requests queued.
      clear_stats();
      dir_req  = 1'b0;
      step_req = 1'b1;
      tick(4);
      step_req = 1'b0;
      wait_step("t5_rise", 50);
      tick(5);
      check("t5_pend_q", 64'(pending), 64'd3);
      enable   = 1'b0;
      step_req = 1'b1;
      tick(2);
      check("t5_pend_0", 64'(pending), 64'd0);
      wait_idle("t5_idle", 200);
      step_req = 1'b0;
      check("t5_width",  64'(width_last), 64'd16);
      check("t5_pulses", 64'(n_rise), 64'd1);
      check("t5_ovr",    64'(overrun), 64'd1);
      overrun_clr = 1'b1;
      tick(1);
      overrun_clr = 1'b0;
      check("t5_ovr_clr", 64'(overrun), 64'd0);
      enable = 1'b1;
      tick(40);
      check("t5_no_more", 64'(n_rise), 64'd1);

      // Wrap at the positive limit, then load coinciding with a step.
      position_load_value = 64'h7FFF_FFFF_FFFF_FFFF;
      position_load = 1'b1;
      tick(1);
      position_load = 1'b0;
      one_req(1'b1);
      wait_idle("t6_idle", 200);
      check("t6_wrap", position, 64'h8000_0000_0000_0000);
      one_req(1'b1);
      tick(1);
      position_load_value = 64'd100;
      position_load = 1'b1;
      tick(1);
      position_load = 1'b0;
      check("t6_ld_step", position, 64'd101);
      wait_idle("t6_idle2", 200);

      // Reset in the middle of a pulse.
      one_req(1'b0);
      wait_step("t6_rise", 50);
      tick(3);
      resetn = 1'b0;
      tick(1);
      check("t6_rst_step", 64'(step_out), 64'd0);
      check("t6_rst_dir",  64'(dir_out),  64'd0);
      check("t6_rst_pos",  position,      64'd0);
      check("t6_rst_pend", 64'(pending),  64'd0);
      check("t6_rst_busy", 64'(busy),     64'd0);
      check("t6_rst_ovr",  64'(overrun),  64'd0);
      resetn = 1'b1;
      tick(5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete, %0d compared", n_cmp);
      $fatal(1);
   end

endmodule
